// File: rtl/drag_race_pkg.sv
// Shared types and helpers for the drag-race timing blocks.
package drag_race_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    DONE,
    FOUL,
    TIMEOUT
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_MAX          = 16'h9999;
  localparam int unsigned TICK_DIV_DEFAULT = 50000;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    bcd_digit_t  d;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      d = r[i*4 +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          r[i*4 +: 4] = '0;
        end else begin
          r[i*4 +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Thousands digit decides first; lower digits only matter on a tie.
  function automatic logic bcd_less(input logic [15:0] a, input logic [15:0] b);
    logic       decided;
    logic       less;
    bcd_digit_t da;
    bcd_digit_t db;
    decided = 1'b0;
    less    = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      da = a[(3-k)*4 +: 4];
      db = b[(3-k)*4 +: 4];
      if (!decided && (da != db)) begin
        decided = 1'b1;
        less    = (da < db);
      end
    end
    return less;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Four-digit cascaded BCD counter, 0000..9999, with synchronous clear.
module bcd_counter
  import drag_race_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] q,
  output logic        at_max
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc) begin
      q <= bcd_inc(q);
    end
  end

  always_comb begin
    at_max = (q == BCD_MAX);
  end

endmodule

// File: rtl/reaction_timer.sv
// Drag-race reaction timer: ms count from green to beam release, latched as BCD.
// Optional session best-time register enabled by defining REACTION_BEST_EN.
module reaction_timer
  import drag_race_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        Green,
  input  logic        Red,
  input  logic        SB,
  input  logic        New_Race,
  output logic [15:0] Time_BCD,
  output logic        Time_Valid,
  output logic        Foul,
  output logic        Timeout,
  output logic        Running
`ifdef REACTION_BEST_EN
  ,
  output logic [15:0] Best_BCD
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state;
  logic            sb_meta;
  logic            sb_s;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            run_entry;
  logic [15:0]     cnt_q;
  logic            cnt_at_max;
  logic [15:0]     latch_val;

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      sb_meta <= 1'b0;
      sb_s    <= 1'b0;
    end else begin
      sb_meta <= SB;
      sb_s    <= sb_meta;
    end
  end

  // A tick in the release cycle is included; saturate rather than wrap at 9999.
  always_comb begin
    tick      = (state == RUN) && (presc == PW'(TICK_DIV - 1));
    run_entry = (state == ARMED) && !Red && sb_s && Green;
    latch_val = cnt_q;
    if (tick) begin
      latch_val = cnt_at_max ? BCD_MAX : bcd_inc(cnt_q);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      presc <= '0;
    end else if (run_entry) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd_counter u_count (
    .clock  (CLOCK_50),
    .reset  (Reset),
    .clear  (run_entry),
    .inc    (tick),
    .q      (cnt_q),
    .at_max (cnt_at_max)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      state      <= IDLE;
      Time_BCD   <= '0;
      Time_Valid <= 1'b0;
      Foul       <= 1'b0;
      Timeout    <= 1'b0;
      Running    <= 1'b0;
`ifdef REACTION_BEST_EN
      Best_BCD   <= BCD_MAX;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sb_s) state <= ARMED;
        end
        ARMED: begin
          if (Red || !sb_s) begin
            state    <= FOUL;
            Foul     <= 1'b1;
            Time_BCD <= '0;
          end else if (Green) begin
            state   <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (Red) begin
            state    <= FOUL;
            Foul     <= 1'b1;
            Running  <= 1'b0;
            Time_BCD <= '0;
          end else if (!sb_s) begin
            state      <= DONE;
            Time_Valid <= 1'b1;
            Running    <= 1'b0;
            Time_BCD   <= latch_val;
`ifdef REACTION_BEST_EN
            if (bcd_less(latch_val, Best_BCD)) Best_BCD <= latch_val;
`endif
          end else if (tick && cnt_at_max) begin
            state    <= TIMEOUT;
            Timeout  <= 1'b1;
            Running  <= 1'b0;
            Time_BCD <= BCD_MAX;
          end
        end
        DONE, FOUL, TIMEOUT: begin
          if (New_Race) begin
            state      <= IDLE;
            Time_BCD   <= '0;
            Time_Valid <= 1'b0;
            Foul       <= 1'b0;
            Timeout    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed, table-driven bench for reaction_timer (TICK_DIV=10, plus a TICK_DIV=2 copy for timeout).
module tb_reaction_timer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n, green, red, sb, new_race;
  logic [15:0] t1, t2;
  logic        v1, f1, to1, r1;
  logic        v2, f2, to2, r2;
`ifdef REACTION_BEST_EN
  logic [15:0] b1, b2;
`endif

  reaction_timer #(.TICK_DIV(10)) u_dut (
    .CLOCK_50   (clk),
    .Reset      (rst_n),
    .Green      (green),
    .Red        (red),
    .SB         (sb),
    .New_Race   (new_race),
    .Time_BCD   (t1),
    .Time_Valid (v1),
    .Foul       (f1),
    .Timeout    (to1),
    .Running    (r1)
`ifdef REACTION_BEST_EN
    ,
    .Best_BCD   (b1)
`endif
  );

  reaction_timer #(.TICK_DIV(2)) u_dut_fast (
    .CLOCK_50   (clk),
    .Reset      (rst_n),
    .Green      (green),
    .Red        (red),
    .SB         (sb),
    .New_Race   (new_race),
    .Time_BCD   (t2),
    .Time_Valid (v2),
    .Foul       (f2),
    .Timeout    (to2),
    .Running    (r2)
`ifdef REACTION_BEST_EN
    ,
    .Best_BCD   (b2)
`endif
  );

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; green = 1'b0; red = 1'b0; sb = 1'b0; new_race = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("rst_time", t1, 16'h0000);
    check("rst_valid", v1, 0);
    check("rst_flags", {f1, to1, r1}, 0);
`ifdef REACTION_BEST_EN
    check("rst_best", b1, 16'h9999);
`endif
  endtask

  task automatic arm();
    sb = 1'b1;
    step(3);
  endtask

  typedef struct {
    bit          do_reset;
    int          kind;       // 0 normal, 1 early release, 2 red in ARMED, 3 simultaneous
    int          ticks;
    logic [15:0] exp_time;
    bit          exp_valid;
    bit          exp_foul;
    logic [15:0] exp_best;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw_run;
    int n;

    vecs[0] = '{1'b1, 0, 400, 16'h0400, 1'b1, 1'b0, 16'h0400};
    vecs[1] = '{1'b0, 0, 250, 16'h0250, 1'b1, 1'b0, 16'h0250};
    vecs[2] = '{1'b0, 0, 300, 16'h0300, 1'b1, 1'b0, 16'h0250};
    vecs[3] = '{1'b0, 1, 0,   16'h0000, 1'b0, 1'b1, 16'h0250};
    vecs[4] = '{1'b0, 2, 0,   16'h0000, 1'b0, 1'b1, 16'h0250};
    vecs[5] = '{1'b0, 3, 0,   16'h0000, 1'b0, 1'b1, 16'h0250};
    vecs[6] = '{1'b1, 0, 253, 16'h0253, 1'b1, 1'b0, 16'h0253};
    vecs[7] = '{1'b0, 0, 10,  16'h0010, 1'b1, 1'b0, 16'h0010};
    vecs[8] = '{1'b0, 0, 0,   16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[9] = '{1'b1, 0, 100, 16'h0100, 1'b1, 1'b0, 16'h0100};

    rst_n = 1'b1; green = 1'b0; red = 1'b0; sb = 1'b0; new_race = 1'b0;
    step(1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_reset) apply_reset();
      arm();
      case (vecs[i].kind)
        0: begin
          green = 1'b1;
          step(1);
          check("green_to_running", r1, 1);
          step(vecs[i].ticks * 10);
          sb = 1'b0;
          step(2);
          check("done_not_yet", v1, 0);
          step(1);
        end
        1: begin
          sb = 1'b0;
          step(3);
        end
        2: begin
          red = 1'b1;
          step(1);
          red = 1'b0;
        end
        default: begin
          sb = 1'b0;
          step(2);
          green = 1'b1;
          saw_run = 1'b0;
          repeat (4) begin
            step(1);
            saw_run |= r1;
          end
          check("simul_no_running", saw_run, 0);
        end
      endcase
      check($sformatf("vec%0d_time", i), t1, vecs[i].exp_time);
      check($sformatf("vec%0d_valid", i), v1, vecs[i].exp_valid);
      check($sformatf("vec%0d_foul", i), f1, vecs[i].exp_foul);
      check($sformatf("vec%0d_to_run", i), {to1, r1}, 0);
`ifdef REACTION_BEST_EN
      check($sformatf("vec%0d_best", i), b1, vecs[i].exp_best);
`endif
      sb = 1'b0; green = 1'b0; red = 1'b0;
      step(3);
      check($sformatf("vec%0d_hold", i), t1, vecs[i].exp_time);
      new_race = 1'b1;
      step(1);
      new_race = 1'b0;
      check($sformatf("vec%0d_newrace", i), {t1, v1, f1, to1, r1}, 0);
    end

    // Reset in the middle of a run, then reset while holding a DONE result.
    apply_reset();
    arm();
    green = 1'b1;
    step(1);
    step(1000);
    check("midrun_running", r1, 1);
    check("midrun_time_unchanged", t1, 16'h0000);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midrun_reset_flags", {v1, f1, to1, r1}, 0);
    check("midrun_reset_time", t1, 16'h0000);
    sb = 1'b0; green = 1'b0;
    step(3);
    arm();
    green = 1'b1;
    step(1);
    step(50);
    sb = 1'b0;
    step(3);
    check("short_done_time", t1, 16'h0005);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("done_reset_time", t1, 16'h0000);
    check("done_reset_valid", v1, 0);
    green = 1'b0;
    step(3);

    // Timeout on the TICK_DIV=2 instance: 10000 ticks = 20000 edges after RUN entry.
    apply_reset();
    arm();
    green = 1'b1;
    step(1);
    check("fast_running", r2, 1);
    n = 0;
    while (!to2 && n < 20100) begin
      step(1);
      n++;
    end
    check("timeout_cycles", n, 20000);
    check("timeout_time", t2, 16'h9999);
    check("timeout_flag_run", {to2, r2}, 2'b10);
    check("timeout_valid_foul", {v2, f2}, 0);
`ifdef REACTION_BEST_EN
    check("timeout_best_unchanged", b2, 16'h9999);
`endif
    sb = 1'b0; green = 1'b0;
    step(3);
    new_race = 1'b1;
    step(1);
    new_race = 1'b0;
    check("timeout_newrace_time", t2, 16'h0000);
    check("timeout_newrace_flags", {v2, f2, to2, r2}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
